// File: rtl/deep_loop_seq_engine.sv
// ---------------------------------------------------------------------------
// deep_loop_seq_engine
//
// Multi-cycle reference for the combinational bounded-loop accumulators.
// A start request in IDLE latches the operand and the loop controls. The
// engine then runs one loop iteration per clock on those latched copies.
// The loop exits normally, or through break_at. The final accumulator,
// the exit reason and the exit index are registered, and they are held
// until the next run completes.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   dlse_start        start request, only looked at in IDLE
//   dlse_data_in      loop operand (DATA_W)
//   dlse_limit        iteration bound; iterations 0..limit-1 (IDX_W)
//   dlse_break_at     index at which the loop breaks (IDX_W)
//   dlse_continue_at  index at which the loop adds limit and skips (IDX_W)
//   dlse_busy         high in RUN and DONE
//   dlse_done         one-cycle pulse; the result outputs are valid here
//   dlse_sum_out      final accumulator value (DATA_W)
//   dlse_broke        last run left through the break path
//   dlse_last_iter    loop index at exit (IDX_W)
//
// DATA_W must be >= IDX_W because limit is zero-extended into the
// accumulator. IDX_W must be >= 2 because the index's low two bits select
// the operation.
// ---------------------------------------------------------------------------
module deep_loop_seq_engine #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dlse_start,
    input  logic [DATA_W-1:0] dlse_data_in,
    input  logic [IDX_W-1:0]  dlse_limit,
    input  logic [IDX_W-1:0]  dlse_break_at,
    input  logic [IDX_W-1:0]  dlse_continue_at,
    output logic              dlse_busy,
    output logic              dlse_done,
    output logic [DATA_W-1:0] dlse_sum_out,
    output logic              dlse_broke,
    output logic [IDX_W-1:0]  dlse_last_iter
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // Operands latched at start; the loop never looks at the live inputs.
    logic [DATA_W-1:0] data_q,  data_d;
    logic [IDX_W-1:0]  limit_q, limit_d;
    logic [IDX_W-1:0]  brk_q,   brk_d;
    logic [IDX_W-1:0]  cont_q,  cont_d;

    // Loop state
    logic [DATA_W-1:0] acc_q,   acc_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;

    // Held result
    logic [DATA_W-1:0] sum_q,   sum_d;
    logic              broke_q, broke_d;
    logic [IDX_W-1:0]  last_q,  last_d;

    // Zero-extended limit, used by the continue path.
    logic [DATA_W-1:0] limit_ext;
    // Result of the index-selected operation for the current iteration.
    logic [DATA_W-1:0] op_res;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            limit_q <= '0;
            brk_q   <= '0;
            cont_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            broke_q <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            limit_q <= limit_d;
            brk_q   <= brk_d;
            cont_q  <= cont_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            broke_q <= broke_d;
            last_q  <= last_d;
        end
    end

    // -----------------------------------------------------------------------
    // Per-iteration datapath
    // -----------------------------------------------------------------------
    always_comb begin
        limit_ext              = '0;
        limit_ext[IDX_W-1:0]   = limit_q;

        op_res = acc_q;
        unique case (idx_q[1:0])
            2'b00:   op_res = acc_q + data_q;   // carry discarded
            2'b01:   op_res = acc_q ^ data_q;
            2'b10:   op_res = acc_q & data_q;
            default: op_res = acc_q | data_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state and loop control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        limit_d = limit_q;
        brk_d   = brk_q;
        cont_d  = cont_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        broke_d = broke_q;
        last_d  = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (dlse_start) begin
                    data_d  = dlse_data_in;
                    limit_d = dlse_limit;
                    brk_d   = dlse_break_at;
                    cont_d  = dlse_continue_at;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // The bound test comes first, so a break or continue
                // index >= limit can never be reached. The break test
                // comes before the continue test, so break wins when the
                // two indices are equal.
                if (idx_q >= limit_q) begin
                    sum_d   = acc_q;
                    broke_d = 1'b0;
                    last_d  = idx_q;
                    state_d = S_DONE;
                end else if (idx_q == brk_q) begin
                    acc_d   = acc_q | data_q;
                    sum_d   = acc_q | data_q;
                    broke_d = 1'b1;
                    last_d  = idx_q;
                    state_d = S_DONE;
                end else if (idx_q == cont_q) begin
                    acc_d   = acc_q + limit_ext;
                    idx_d   = idx_q + 1'b1;
                end else begin
                    acc_d   = op_res;
                    // idx_q < limit_q here, so the increment cannot wrap.
                    idx_d   = idx_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign dlse_busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign dlse_done      = (state_q == S_DONE);
    assign dlse_sum_out   = sum_q;
    assign dlse_broke     = broke_q;
    assign dlse_last_iter = last_q;

endmodule

// File: tb/tb_deep_loop_seq_engine.sv
// ---------------------------------------------------------------------------
// Directed bench for deep_loop_seq_engine. Each run pushes its expected
// result to a scoreboard queue. The entry is popped when done pulses.
// Cycle numbering: cycle 0 is the cycle in which start is sampled in IDLE.
// ---------------------------------------------------------------------------
module tb_deep_loop_seq_engine;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 4;
    localparam int BUDGET = 40;

    logic              clk;
    logic              rst;
    logic              dlse_start;
    logic [DATA_W-1:0] dlse_data_in;
    logic [IDX_W-1:0]  dlse_limit;
    logic [IDX_W-1:0]  dlse_break_at;
    logic [IDX_W-1:0]  dlse_continue_at;
    logic              dlse_busy;
    logic              dlse_done;
    logic [DATA_W-1:0] dlse_sum_out;
    logic              dlse_broke;
    logic [IDX_W-1:0]  dlse_last_iter;

    deep_loop_seq_engine #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .dlse_start       (dlse_start),
        .dlse_data_in     (dlse_data_in),
        .dlse_limit       (dlse_limit),
        .dlse_break_at    (dlse_break_at),
        .dlse_continue_at (dlse_continue_at),
        .dlse_busy        (dlse_busy),
        .dlse_done        (dlse_done),
        .dlse_sum_out     (dlse_sum_out),
        .dlse_broke       (dlse_broke),
        .dlse_last_iter   (dlse_last_iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] sum;
        logic              broke;
        logic [IDX_W-1:0]  last;
        int                done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Launch one run and wait for its done pulse.
    // With hold=1, start stays high through RUN and DONE. It is dropped
    // during the done cycle. No second run may follow from that.
    task automatic run(input string name,
                       input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] l,
                       input logic [IDX_W-1:0] b, input logic [IDX_W-1:0] c,
                       input logic [DATA_W-1:0] esum, input logic ebroke,
                       input logic [IDX_W-1:0] elast, input int ecyc, input bit hold);
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge clk);
        dlse_data_in = d; dlse_limit = l; dlse_break_at = b; dlse_continue_at = c;
        dlse_start = 1'b1;
        e.sum = esum; e.broke = ebroke; e.last = elast; e.done_cyc = ecyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) dlse_start = 1'b0;
        // The engine must work only on the latched copies.
        dlse_data_in = ~d; dlse_limit = ~l; dlse_break_at = ~b; dlse_continue_at = ~c;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < BUDGET) begin
            @(negedge clk);
            if (cyc == 1) chk({name, ".busy_rise"}, 32'(dlse_busy), 32'd1);
            if (dlse_done) seen = 1'b1;
            else cyc++;
        end
        dlse_start = 1'b0;
        e = sb.pop_front();
        chk({name, ".done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, ".done_cycle"}, 32'(cyc), 32'(e.done_cyc));
            chk({name, ".sum_out"}, 32'(dlse_sum_out), 32'(e.sum));
            chk({name, ".broke"}, 32'(dlse_broke), 32'(e.broke));
            chk({name, ".last_iter"}, 32'(dlse_last_iter), 32'(e.last));
        end
        @(negedge clk);
        chk({name, ".busy_fall"}, 32'(dlse_busy), 32'd0);
        chk({name, ".done_pulse"}, 32'(dlse_done), 32'd0);
        chk({name, ".sum_held"}, 32'(dlse_sum_out), 32'(e.sum));
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk({name, ".no_rerun"}, 32'(dlse_busy), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; dlse_start = 1'b0; dlse_data_in = '0;
        dlse_limit = '0; dlse_break_at = '0; dlse_continue_at = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", 32'(dlse_busy), 32'd0);
        chk("reset.done", 32'(dlse_done), 32'd0);
        chk("reset.sum_out", 32'(dlse_sum_out), 32'd0);
        chk("reset.broke", 32'(dlse_broke), 32'd0);
        chk("reset.last_iter", 32'(dlse_last_iter), 32'd0);
        rst = 1'b0;

        //   name       data   lim  brk  cont  sum    brk  last cyc hold
        run("basic",    8'h0C, 4,   15,  15,   8'h0C, 0,   4,   6,  0);
        run("cont",     8'h0C, 4,   15,  1,    8'h0C, 0,   4,   6,  0);
        run("brk_coll", 8'h0C, 4,   2,   2,    8'h0C, 1,   2,   4,  0);
        run("brk0",     8'h5A, 6,   0,   3,    8'h5A, 1,   0,   2,  0);
        run("lim0",     8'hAB, 0,   0,   0,    8'h00, 0,   0,   2,  1);
        run("lim15",    8'h01, 15,  15,  15,   8'h01, 0,   15,  17, 0);
        run("wrap",     8'hF0, 5,   9,   15,   8'hE0, 0,   5,   7,  0);

        // Reset during cycle 3 of a limit=8 run.
        @(negedge clk);
        dlse_data_in = 8'h0C; dlse_limit = 4'd8; dlse_break_at = 4'd15; dlse_continue_at = 4'd15;
        dlse_start = 1'b1;
        @(posedge clk);
        #1;
        dlse_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("abort.running", 32'(dlse_busy), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort.busy", 32'(dlse_busy), 32'd0);
        chk("abort.done", 32'(dlse_done), 32'd0);
        chk("abort.sum_out", 32'(dlse_sum_out), 32'd0);
        chk("abort.last_iter", 32'(dlse_last_iter), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(dlse_done), 32'd0);
        end

        // Clean run after the abort: i0 continue +3, i1 xor, i2 and.
        run("post_rst", 8'h35, 3,   15,  0,    8'h34, 0,   3,   5,  0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
